// File: rtl/bcd_stopwatch.sv
// bcd_stopwatch
//   Four-digit BCD stopwatch (SS.hh, 00.00 .. 99.99) advanced by a prescaled
//   hundredth-second tick. The digits feed a four-digit seven-segment
//   multiplexer directly: dig0 is the rightmost (hundredths) digit.
//
// Parameters
//   TICK_DIV  clk cycles per hundredth tick (>= 2)
//   WRAP      1: 99.99 rolls to 00.00 and keeps running
//             0: saturate at 99.99, pause, set the sticky overflow flag
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   btn_start  start/stop toggle button (debounced level, asynchronous)
//   btn_clear  clear button (debounced level, asynchronous)
//   btn_lap    lap display freeze toggle (debounced level, asynchronous)
//   dig0..dig3 displayed BCD digits (hundredths, tenths, s units, s tens)
//   running    1 while in RUNNING
//   lap_hold   1 while the display shows the lap snapshot
//   overflow   sticky saturation flag (only ever set when WRAP = 0)
//   dbg_state  current FSM state (0 IDLE, 1 RUNNING, 2 PAUSED)
//
// Buttons: each goes through a 2-flop synchronizer and a previous-value
// register; a press is the one-cycle rising edge of the synchronized level.
// Coincident presses resolve as clear > start > lap.

module bcd_stopwatch #(
  parameter int TICK_DIV = 1_000_000,
  parameter bit WRAP     = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       btn_clear,
  input  logic       btn_lap,
  output logic [3:0] dig0,
  output logic [3:0] dig1,
  output logic [3:0] dig2,
  output logic [3:0] dig3,
  output logic       running,
  output logic       lap_hold,
  output logic       overflow,
  output logic [1:0] dbg_state
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUNNING = 2'd1,
    S_PAUSED  = 2'd2
  } state_t;

  state_t state;

  // Bit order in all button vectors: {lap, clear, start}
  logic [2:0] btn_raw;
  logic [2:0] sync1;
  logic [2:0] sync2;
  logic [2:0] prev;
  logic [2:0] pulse;

  logic [PW-1:0] presc;
  logic [15:0]   count;
  logic [15:0]   snap;
  logic [15:0]   count_inc;
  logic          tick;
  logic          at_max;
  logic          start_p;
  logic          clear_p;
  logic          lap_p;

  assign btn_raw = {btn_lap, btn_clear, btn_start};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign pulse   = sync2 & ~prev;
  assign start_p = pulse[0];
  assign clear_p = pulse[1];
  assign lap_p   = pulse[2];

  assign tick   = (state == S_RUNNING) && (presc == PRESC_MAX);
  assign at_max = (count == 16'h9999);

  // BCD ripple increment. A digit at 9 (or, defensively, any value above 9)
  // returns to 0 and passes the carry on, so digits can never leave 0..9.
  always_comb begin
    logic carry;
    count_inc = count;
    carry     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (count[4*i +: 4] >= 4'd9) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = count[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      presc    <= '0;
      count    <= '0;
      snap     <= '0;
      lap_hold <= 1'b0;
      overflow <= 1'b0;
    end else if (clear_p) begin
      // Clear overrides everything else in the same cycle, including a tick.
      state    <= S_IDLE;
      presc    <= '0;
      count    <= '0;
      snap     <= '0;
      lap_hold <= 1'b0;
      overflow <= 1'b0;
    end else begin
      // The prescaler only moves while RUNNING, so a pause keeps the partial
      // tick and a resume finishes it.
      if (state == S_RUNNING) begin
        presc <= tick ? '0 : presc + 1'b1;
      end

      if (tick) begin
        if (at_max) begin
          if (WRAP) begin
            count <= '0;
          end else begin
            state    <= S_PAUSED;
            overflow <= 1'b1;
          end
        end else begin
          count <= count_inc;
        end
      end

      // A start press in the tick cycle still lets the increment above land;
      // both resulting state changes agree on PAUSED when they collide.
      if (start_p) begin
        case (state)
          S_IDLE:    state <= S_RUNNING;
          S_RUNNING: state <= S_PAUSED;
          S_PAUSED:  if (!overflow) state <= S_RUNNING;
          default:   state <= S_IDLE;
        endcase
      end else if (lap_p && (state != S_IDLE)) begin
        if (lap_hold) begin
          lap_hold <= 1'b0;
        end else begin
          snap     <= count;
          lap_hold <= 1'b1;
        end
      end
    end
  end

  assign dig0      = lap_hold ? snap[3:0]   : count[3:0];
  assign dig1      = lap_hold ? snap[7:4]   : count[7:4];
  assign dig2      = lap_hold ? snap[11:8]  : count[11:8];
  assign dig3      = lap_hold ? snap[15:12] : count[15:12];
  assign running   = (state == S_RUNNING);
  assign dbg_state = state;

endmodule
